// File: rtl/axi_res_tbl_ctrl_if.sv
// Bundle of command, response and reservation-table signals for
// axi_res_tbl_ctrl. The slave modport is the controller's view; the master
// modport is the view of whatever issues commands and serves table requests.
interface axi_res_tbl_ctrl_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 5
);
    // command channel
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [1:0]                cmd_op_i;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_i;
    logic [AXI_ID_WIDTH-1:0]   cmd_id_i;

    // response channel
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic                      rsp_exokay_o;
    logic [1:0]                rsp_op_o;

    // reservation table: set
    logic                      set_req_o;
    logic                      set_gnt_i;
    logic [AXI_ADDR_WIDTH-1:0] set_addr_o;
    logic [AXI_ID_WIDTH-1:0]   set_id_o;

    // reservation table: check
    logic                      check_req_o;
    logic                      check_gnt_i;
    logic                      check_res_i;
    logic [AXI_ADDR_WIDTH-1:0] check_addr_o;
    logic [AXI_ID_WIDTH-1:0]   check_id_o;

    // reservation table: clear
    logic                      clr_req_o;
    logic                      clr_gnt_i;
    logic [AXI_ADDR_WIDTH-1:0] clr_addr_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_id_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_exokay_o, rsp_op_o,
        input  rsp_ready_i,
        output set_req_o, set_addr_o, set_id_o,
        input  set_gnt_i,
        output check_req_o, check_addr_o, check_id_o,
        input  check_gnt_i, check_res_i,
        output clr_req_o, clr_addr_o,
        input  clr_gnt_i
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_id_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_exokay_o, rsp_op_o,
        output rsp_ready_i,
        input  set_req_o, set_addr_o, set_id_o,
        output set_gnt_i,
        input  check_req_o, check_addr_o, check_id_o,
        output check_gnt_i, check_res_i,
        input  clr_req_o, clr_addr_o,
        output clr_gnt_i
    );
endinterface

// File: rtl/axi_res_tbl_ctrl.sv
// axi_res_tbl_ctrl: sequences LR / SC / plain-write commands against an
// external reservation table (set, check, clear ports) and returns one
// response per command with an exclusive-OK flag.
// Optional build macro: AXI_RES_TBL_CTRL_ADDR_ALIGN_EN -- when defined the
// latched address has bits [2:0] cleared (8-byte reservation granule).
// All outputs come straight from flops; request outputs are loaded from the
// next-state value so they track the FSM state exactly.
module axi_res_tbl_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    axi_res_tbl_ctrl_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SET   = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_CLR   = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_LR    = 2'b01;
    localparam logic [1:0] OP_SC    = 2'b10;

    // Reservation granule applied to the address before it is latched.
    function automatic logic [AXI_ADDR_WIDTH-1:0] granule_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr
    );
`ifdef AXI_RES_TBL_CTRL_ADDR_ALIGN_EN
        return addr & {{(AXI_ADDR_WIDTH-3){1'b1}}, 3'b000};
`else
        return addr;
`endif
    endfunction

    logic [2:0]                state_r;
    logic [2:0]                state_nxt_s;
    logic                      accept_s;
    logic                      exokay_nxt_s;

    logic [1:0]                op_r;
    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [AXI_ID_WIDTH-1:0]   id_r;
    logic                      res_r;

    logic                      cmd_ready_r;
    logic                      set_req_r;
    logic                      check_req_r;
    logic                      clr_req_r;
    logic                      rsp_valid_r;
    logic                      rsp_exokay_r;

    // Next-state, command acceptance and response exclusive-OK decision.
    always_comb begin
        state_nxt_s  = state_r;
        accept_s     = 1'b0;
        exokay_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    accept_s = 1'b1;
                    case (bus.cmd_op_i)
                        OP_LR:    state_nxt_s = ST_SET;
                        OP_SC:    state_nxt_s = ST_CHECK;
                        OP_WRITE: state_nxt_s = ST_CLR;
                        default:  state_nxt_s = ST_RESP;  // reserved op, exokay 0
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SET: begin
                if (bus.set_gnt_i) begin
                    state_nxt_s  = ST_RESP;
                    exokay_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SET;
                end
            end
            ST_CHECK: begin
                if (bus.check_gnt_i) begin
                    if (bus.check_res_i) begin
                        state_nxt_s = ST_CLR;
                    end else begin
                        state_nxt_s  = ST_RESP;
                        exokay_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_CLR: begin
                if (bus.clr_gnt_i) begin
                    state_nxt_s  = ST_RESP;
                    exokay_nxt_s = res_r;
                end else begin
                    state_nxt_s = ST_CLR;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s  = ST_RESP;
                    exokay_nxt_s = rsp_exokay_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake/request outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            cmd_ready_r  <= 1'b1;
            set_req_r    <= 1'b0;
            check_req_r  <= 1'b0;
            clr_req_r    <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_exokay_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cmd_ready_r  <= (state_nxt_s == ST_IDLE);
            set_req_r    <= (state_nxt_s == ST_SET);
            check_req_r  <= (state_nxt_s == ST_CHECK);
            clr_req_r    <= (state_nxt_s == ST_CLR);
            rsp_valid_r  <= (state_nxt_s == ST_RESP);
            rsp_exokay_r <= exokay_nxt_s;
        end
    end

    // Command latch and SC check-result capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_r   <= 2'b00;
            addr_r <= {AXI_ADDR_WIDTH{1'b0}};
            id_r   <= {AXI_ID_WIDTH{1'b0}};
            res_r  <= 1'b0;
        end else if (accept_s) begin
            op_r   <= bus.cmd_op_i;
            addr_r <= granule_addr(bus.cmd_addr_i);
            id_r   <= bus.cmd_id_i;
            res_r  <= 1'b0;
        end else if ((state_r == ST_CHECK) && bus.check_gnt_i) begin
            res_r  <= bus.check_res_i;
        end else begin
            res_r  <= res_r;
        end
    end

    assign bus.cmd_ready_o  = cmd_ready_r;
    assign bus.rsp_valid_o  = rsp_valid_r;
    assign bus.rsp_exokay_o = rsp_exokay_r;
    assign bus.rsp_op_o     = op_r;

    assign bus.set_req_o    = set_req_r;
    assign bus.set_addr_o   = addr_r;
    assign bus.set_id_o     = id_r;

    assign bus.check_req_o  = check_req_r;
    assign bus.check_addr_o = addr_r;
    assign bus.check_id_o   = id_r;

    assign bus.clr_req_o    = clr_req_r;
    assign bus.clr_addr_o   = addr_r;

endmodule

// File: tb/tb_axi_res_tbl_ctrl.sv
// Self-checking bench for axi_res_tbl_ctrl. Each command is checked against a
// transaction-level model: the op and check result give the list of table
// phases to visit, and every cycle of every phase is compared against it.
module tb_axi_res_tbl_ctrl;

    localparam int AW = 64;
    localparam int IW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi_res_tbl_ctrl_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) bus ();

    axi_res_tbl_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {cmd_ready, set_req, check_req, clr_req, rsp_valid}
    function automatic logic [4:0] ctrl_vec();
        return {bus.cmd_ready_o, bus.set_req_o, bus.check_req_o, bus.clr_req_o, bus.rsp_valid_o};
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef AXI_RES_TBL_CTRL_ADDR_ALIGN_EN
        return (a / 64'd8) * 64'd8;
`else
        return a;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic noise_grants();
        bus.set_gnt_i   = 1'($urandom_range(0, 1));
        bus.check_gnt_i = 1'($urandom_range(0, 1));
        bus.clr_gnt_i   = 1'($urandom_range(0, 1));
        bus.check_res_i = 1'($urandom_range(0, 1));
    endtask

    // Phase codes: 1 = set, 2 = check, 3 = clear.
    task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic res, input int st0, input int st1, input int rstall);
        logic [AW-1:0] ea;
        int            phases[$];
        logic          ex;
        int            st;
        logic [4:0]    ev;
        ea = exp_addr(addr);
        case (op)
            2'b01:   begin phases = '{1};    ex = 1'b1; end
            2'b10:   begin if (res) begin phases = '{2, 3}; ex = 1'b1; end
                           else     begin phases = '{2};    ex = 1'b0; end end
            2'b00:   begin phases = '{3};    ex = 1'b0; end
            default: begin phases = '{};     ex = 1'b0; end
        endcase

        check_val("idle_before_cmd", ctrl_vec(), 5'b10000);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_addr_i  = addr;
        bus.cmd_id_i    = id;
        bus.rsp_ready_i = 1'($urandom_range(0, 1));
        noise_grants();
        next_cycle();

        // Leave a junk command pending: it must not be accepted until idle.
        bus.cmd_op_i   = 2'($urandom);
        bus.cmd_addr_i = {$urandom, $urandom};
        bus.cmd_id_i   = 5'($urandom);

        foreach (phases[p]) begin
            st = (p == 0) ? st0 : st1;
            for (int k = 0; k <= st; k++) begin
                ev = (phases[p] == 1) ? 5'b01000 : (phases[p] == 2) ? 5'b00100 : 5'b00010;
                check_val($sformatf("phase%0d_ctrl", phases[p]), ctrl_vec(), ev);
                case (phases[p])
                    1: begin
                        check_val("set_addr", bus.set_addr_o, ea);
                        check_val("set_id", bus.set_id_o, id);
                    end
                    2: begin
                        check_val("check_addr", bus.check_addr_o, ea);
                        check_val("check_id", bus.check_id_o, id);
                    end
                    default: check_val("clr_addr", bus.clr_addr_o, ea);
                endcase
                noise_grants();
                bus.rsp_ready_i = 1'($urandom_range(0, 1));
                case (phases[p])
                    1: bus.set_gnt_i = (k == st);
                    2: begin
                        bus.check_gnt_i = (k == st);
                        if (k == st) bus.check_res_i = res;
                    end
                    default: bus.clr_gnt_i = (k == st);
                endcase
                next_cycle();
            end
        end

        for (int k = 0; k <= rstall; k++) begin
            check_val("resp_ctrl", ctrl_vec(), 5'b00001);
            check_val("resp_exokay", bus.rsp_exokay_o, ex);
            check_val("resp_op", bus.rsp_op_o, op);
            noise_grants();
            bus.rsp_ready_i = (k == rstall);
            if (k == rstall) bus.cmd_valid_i = 1'b0;
            next_cycle();
        end
        bus.rsp_ready_i = 1'b0;
        check_val("back_to_idle", ctrl_vec(), 5'b10000);
    endtask

    task automatic reset_in_check();
        check_val("rst_test_idle", ctrl_vec(), 5'b10000);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 2'b10;
        bus.cmd_addr_i  = 64'h1000;
        bus.cmd_id_i    = 5'd3;
        bus.set_gnt_i   = 1'b0;
        bus.check_gnt_i = 1'b0;
        bus.clr_gnt_i   = 1'b0;
        bus.rsp_ready_i = 1'b1;
        next_cycle();
        bus.cmd_valid_i = 1'b0;
        check_val("rst_test_in_check", ctrl_vec(), 5'b00100);
        next_cycle();
        check_val("rst_test_still_check", ctrl_vec(), 5'b00100);
        #2 rst_n = 1'b0;
        #1 check_val("rst_async_drop", ctrl_vec(), 5'b10000);
        // Commands offered during reset must be ignored.
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 2'b01;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check_val("rst_hold_ctrl", ctrl_vec(), 5'b10000);
        end
        bus.cmd_valid_i = 1'b0;
        rst_n = 1'b1;
        next_cycle();
        check_val("post_rst_ctrl", ctrl_vec(), 5'b10000);
        check_val("post_rst_op", bus.rsp_op_o, 2'b00);
        check_val("post_rst_addr", bus.set_addr_o, 64'h0);
        check_val("post_rst_exokay", bus.rsp_exokay_o, 1'b0);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'b00;
        bus.cmd_addr_i  = 64'h0;
        bus.cmd_id_i    = 5'd0;
        bus.rsp_ready_i = 1'b0;
        bus.set_gnt_i   = 1'b0;
        bus.check_gnt_i = 1'b0;
        bus.check_res_i = 1'b0;
        bus.clr_gnt_i   = 1'b0;

        repeat (2) @(negedge clk);
        check_val("reset_ctrl", ctrl_vec(), 5'b10000);
        check_val("reset_exokay", bus.rsp_exokay_o, 1'b0);
        check_val("reset_op", bus.rsp_op_o, 2'b00);
        rst_n = 1'b1;
        next_cycle();

        // LR with immediate grant, then SC success / failure at same address.
        run_txn(2'b01, 64'h1000, 5'd3, 1'b0, 0, 0, 0);
        run_txn(2'b10, 64'h1000, 5'd3, 1'b1, 0, 0, 0);
        run_txn(2'b10, 64'h1000, 5'd3, 1'b0, 0, 0, 0);
        // Plain write with clear grant stalled 5 cycles.
        run_txn(2'b00, 64'h2008, 5'd7, 1'b0, 5, 0, 0);
        // Response backpressure for 4 cycles.
        run_txn(2'b01, 64'h3000, 5'd9, 1'b0, 0, 0, 4);
        // Reserved op goes straight to a failing response.
        run_txn(2'b11, 64'h4000, 5'd1, 1'b0, 0, 0, 2);
        // Unaligned LR address (granule handling).
        run_txn(2'b01, 64'h1005, 5'd3, 1'b0, 0, 0, 0);
        check_val("granule_set_addr", bus.set_addr_o, exp_addr(64'h1005));

        reset_in_check();
        run_txn(2'b01, 64'h5008, 5'd2, 1'b0, 1, 0, 1);

        for (int n = 0; n < 300; n++) begin
            run_txn(2'($urandom), {$urandom, $urandom}, 5'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_res_tbl_ctrl.md
AXI_RES_TBL_CTRL -- requirements
Module: axi_res_tbl_ctrl

Interface
REQ-001 Parameters SHALL be: AXI_ADDR_WIDTH, default 64, address width; AXI_ID_WIDTH, default 5, ID width.
REQ-002 Clocking SHALL use one clock; reset is asynchronous and active-low; ports: clk_i input 1, rising-edge clock; rst_ni input 1, async active-low reset.
REQ-003 cmd_valid_i input 1 command valid; cmd_ready_o output 1 command accepted; cmd_op_i input 2 op (00 plain write, 01 LR, 10 SC, 11 reserved); cmd_addr_i input AXI_ADDR_WIDTH; cmd_id_i input AXI_ID_WIDTH.
REQ-004 rsp_valid_o output 1 response valid; rsp_ready_i input 1 response taken; rsp_exokay_o output 1 exclusive-OK; rsp_op_o output 2 echo of accepted op.
REQ-005 Table ports SHALL be: set_req_o output 1, set_gnt_i input 1, set_addr_o output AXI_ADDR_WIDTH, set_id_o output AXI_ID_WIDTH; check_req_o output 1, check_gnt_i input 1, check_res_i input 1, check_addr_o output AXI_ADDR_WIDTH, check_id_o output AXI_ID_WIDTH; clr_req_o output 1, clr_gnt_i input 1, clr_addr_o output AXI_ADDR_WIDTH.

Function
REQ-006 FSM states SHALL be IDLE, SET, CHECK, CLR, RESP; exactly one state active.
REQ-007 cmd_ready_o SHALL be 1 only in IDLE; one command in flight at most.
REQ-008 On cmd_valid_i & cmd_ready_o the block SHALL latch op, addr, id; next state: LR->SET, SC->CHECK, write->CLR, reserved->RESP with exokay 0.
REQ-009 set_req_o SHALL be 1 exactly while in SET; check_req_o exactly in CHECK; clr_req_o exactly in CLR; never two simultaneously.
REQ-010 set/check/clr address and ID outputs SHALL drive the latched values, stable throughout the request.
REQ-011 SET SHALL hold until set_gnt_i=1, then go to RESP with exokay 1.
REQ-012 CHECK SHALL hold until check_gnt_i=1; check_res_i sampled in the grant cycle; 1 -> CLR with result 1; 0 -> RESP with exokay 0.
REQ-013 CLR SHALL hold until clr_gnt_i=1, then go to RESP; exokay = latched result (0 for plain write, 1 for successful SC).
REQ-014 RESP SHALL assert rsp_valid_o with stable rsp_exokay_o/rsp_op_o until rsp_ready_i=1, then return to IDLE.
REQ-015 Grants arriving in states that do not request them SHALL be ignored.
REQ-016 Latency with immediate grants and rsp_ready_i=1: LR 2 cycles accept-to-response-accept; plain write 2; failed SC 2; successful SC 3.
REQ-017 Unbounded grant stalls SHALL be tolerated without state change or output glitch.

Reset
REQ-018 While rst_ni=0 the FSM SHALL be IDLE and latched op/addr/id/result zero; all req outputs, rsp_valid_o, rsp_exokay_o 0; rsp_op_o 00; cmd_ready_o 1.
REQ-019 Reset mid-operation SHALL abort immediately; no pending request or response survives.
REQ-020 Commands presented while rst_ni=0 SHALL NOT be latched.

Configuration
REQ-021 Macro AXI_RES_TBL_CTRL_ADDR_ALIGN_EN: when defined, latched address SHALL have bits [2:0] forced to 0 before driving table ports (8-byte reservation granule).
REQ-022 Without AXI_RES_TBL_CTRL_ADDR_ALIGN_EN the address SHALL pass unmodified; all other behaviour identical.

Verification
REQ-023 LR addr 0x1000 id 3, set_gnt_i immediate -> set_req_o one cycle with set_addr_o 0x1000, set_id_o 3; rsp exokay 1, op 01.
REQ-024 SC addr 0x1000 id 3, check_res_i=1 -> check then clr_req_o with clr_addr_o 0x1000; rsp exokay 1; SC with check_res_i=0 -> no clr_req_o, exokay 0.
REQ-025 Write addr 0x2008, clr_gnt_i held 0 for 5 cycles -> clr_req_o high 6 cycles, cmd_ready_o 0 throughout, rsp exokay 0.
REQ-026 rsp_ready_i low 4 cycles -> rsp_valid_o and outputs stable 5 cycles; new cmd_valid_i not accepted until IDLE.
REQ-027 rst_ni pulsed low while in CHECK -> check_req_o drops asynchronously, rsp never issued, cmd_ready_o 1 after reset.
REQ-028 With ADDR_ALIGN_EN, LR addr 0x1005 -> set_addr_o 0x1000; without it -> 0x1005.
